// File: rtl/core_seq_if.sv
// core_seq_if: the core's shared memory port (request/ack handshake)
interface core_seq_if;
    logic mem_req;
    logic mem_we;
    logic mem_inst;
    logic mem_ack;
    modport master(output mem_req, mem_we, mem_inst, input mem_ack);
    modport slave(input mem_req, mem_we, mem_inst, output mem_ack);
endinterface

// File: rtl/core_seq.sv
// core_seq: multi-cycle RV32I sequencer driving datapath enables and the shared memory port
module core_seq #(
    parameter int XLEN = 32,
    parameter int TO_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    core_seq_if.master      bus,
    input  logic            is_load,
    input  logic            is_store,
    input  logic            is_branch,
    input  logic            is_jmp,
    input  logic            rd_w,
    input  logic            illegal,
    input  logic            br_taken,
    output logic            ir_we,
    output logic            mdr_we,
    output logic            pc_we,
    output logic            pc_sel,
    output logic            rf_we,
    output logic [1:0]      rf_src,
    output logic            halted,
    output logic [1:0]      fault,
    output logic [XLEN-1:0] retired
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
    localparam logic [TO_W-1:0] TO_LAST = ~TO_W'(1);
    state_t          state;
    logic            taken;
    logic [TO_W-1:0] to_cnt;
    logic            req;
    logic            expired;
    assign req     = state == FETCH || state == MEM;
    // this un-acked cycle is the (2^TO_W-1)th in a row
    assign expired = !bus.mem_ack && to_cnt == TO_LAST;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            taken   <= 1'b0;
            to_cnt  <= '0;
            fault   <= 2'b00;
            retired <= '0;
        end else begin
            to_cnt <= (req && !bus.mem_ack) ? to_cnt + 1'b1 : '0;
            case (state)
                FETCH: begin
                    if (bus.mem_ack) state <= DECODE;
                    else if (expired) begin
                        state <= HALT;
                        fault <= 2'b10;
                    end
                end
                DECODE: begin
                    if (illegal) begin
                        state <= HALT;
                        fault <= 2'b01;
                    end else state <= EXEC;
                end
                EXEC: begin
                    taken <= is_jmp | (is_branch & br_taken);
                    state <= (is_load | is_store) ? MEM : WB;
                end
                MEM: begin
                    if (bus.mem_ack) state <= WB;
                    else if (expired) begin
                        state <= HALT;
                        fault <= 2'b10;
                    end
                end
                WB: begin
                    retired <= retired + 1'b1;
                    taken   <= 1'b0;
                    state   <= FETCH;
                end
                default: state <= HALT;
            endcase
        end
    end
    assign bus.mem_req  = req;
    assign bus.mem_we   = state == MEM && is_store;
    assign bus.mem_inst = state == FETCH;
    assign ir_we        = state == FETCH && bus.mem_ack;
    assign mdr_we       = state == MEM && bus.mem_ack && is_load;
    assign pc_we        = state == WB;
    assign pc_sel       = state == WB && taken;
    assign rf_we        = state == WB && rd_w;
    assign rf_src       = state != WB ? 2'b00 : is_jmp ? 2'b10 : is_load ? 2'b01 : 2'b00;
    assign halted       = state == HALT;
endmodule

// File: tb/tb_core_seq.sv
// tb_core_seq: vector table, multi-cycle corner sequences and randomized model check for core_seq
module tb_core_seq;
    localparam int XL = 8;
    // observed output bundle: {req,we,inst,ir_we,mdr_we,pc_we,pc_sel,rf_we,rf_src,halted,fault}
    localparam logic [12:0] REQ  = 13'h1000, WE   = 13'h0800, INST = 13'h0400, IRW = 13'h0200;
    localparam logic [12:0] MDRW = 13'h0100, PCW  = 13'h0080, PCS  = 13'h0040, RFW = 13'h0020;
    localparam logic [12:0] SRC1 = 13'h0008, SRC2 = 13'h0010, HLT  = 13'h0004;
    localparam logic [12:0] FILL = 13'h0001, FTO  = 13'h0002;
    typedef struct {
        logic [5:0] cls;
        int         fw;
        int         mw;
        int         cyc;
        logic [3:0] wb;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic is_load = 1'b0, is_store = 1'b0, is_branch = 1'b0, is_jmp = 1'b0;
    logic rd_w = 1'b0, illegal = 1'b0, br_taken = 1'b0;
    logic ir_we, mdr_we, pc_we, pc_sel, rf_we, halted;
    logic [1:0] rf_src, fault;
    logic [XL-1:0] retired;
    logic [12:0] outs, last_outs;
    int vectors = 0;
    int errors = 0;
    int exp_ret = 0;
    vec_t tbl[11];
    core_seq_if bus();
    core_seq #(.XLEN(XL), .TO_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .is_load(is_load), .is_store(is_store), .is_branch(is_branch), .is_jmp(is_jmp),
        .rd_w(rd_w), .illegal(illegal), .br_taken(br_taken),
        .ir_we(ir_we), .mdr_we(mdr_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
        .rf_src(rf_src), .halted(halted), .fault(fault), .retired(retired)
    );
    assign outs = {bus.mem_req, bus.mem_we, bus.mem_inst, ir_we, mdr_we, pc_we, pc_sel, rf_we,
                   rf_src, halted, fault};
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask
    // one clock: drive ack, compare outputs and retired mid-cycle, advance past the edge
    task automatic step(input logic ack, input logic [12:0] exp, input string nm);
        bus.mem_ack = ack;
        @(negedge clk);
        last_outs = outs;
        vectors++;
        if (outs !== exp || retired !== XL'(exp_ret)) begin
            errors++;
            $display("FAIL %s: outs=%h retired=%0d, expected outs=%h retired=%0d",
                     nm, outs, retired, exp, XL'(exp_ret));
        end
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        bus.mem_ack = 1'b0;
        rst_n = 1'b0;
        exp_ret = 0;
        step(1'b0, REQ | INST, "reset_a");
        step(1'b0, REQ | INST, "reset_b");
        rst_n = 1'b1;
    endtask
    // one instruction, cls = {load,store,branch,jmp,rd_w,br_taken}; fw/mw = wait cycles before ack
    task automatic run_insn(input logic [5:0] cls, input int fw, input int mw,
                            output int cyc, output logic [3:0] wb);
        logic ld, st, br, jmp, rd, brt, tk;
        logic [12:0] wbv;
        {ld, st, br, jmp, rd, brt} = cls;
        tk = jmp | (br & brt);
        cyc = 0;
        for (int i = 0; i <= fw; i++) begin
            {is_load, is_store, is_branch, is_jmp, rd_w, illegal, br_taken} = 7'($urandom);
            step(i == fw, REQ | INST | (i == fw ? IRW : '0), "fetch");
            cyc++;
        end
        {is_load, is_store, is_branch, is_jmp, rd_w, illegal} = {ld, st, br, jmp, rd, 1'b0};
        br_taken = ~brt;
        step(1'($urandom), '0, "decode");
        br_taken = brt;
        step(1'($urandom), '0, "exec");
        br_taken = ~brt;
        cyc += 2;
        if (ld | st)
            for (int i = 0; i <= mw; i++) begin
                step(i == mw, REQ | (st ? WE : '0) | ((i == mw && ld) ? MDRW : '0), "mem");
                cyc++;
            end
        wbv = PCW | (tk ? PCS : '0) | (rd ? RFW : '0) | (jmp ? SRC2 : ld ? SRC1 : '0);
        step(1'($urandom), wbv, "wb");
        cyc++;
        wb = last_outs[6:3];
        exp_ret = (exp_ret + 1) % (1 << XL);
    endtask
    initial begin
        int cyc;
        logic [3:0] wb;
        logic [5:0] cls;
        tbl[0]  = '{6'b000010, 0, 0, 4, 4'b0100};
        tbl[1]  = '{6'b100010, 0, 3, 8, 4'b0101};
        tbl[2]  = '{6'b001001, 0, 0, 4, 4'b1000};
        tbl[3]  = '{6'b001000, 0, 0, 4, 4'b0000};
        tbl[4]  = '{6'b000110, 0, 0, 4, 4'b1110};
        tbl[5]  = '{6'b001110, 0, 0, 4, 4'b1110};
        tbl[6]  = '{6'b010000, 2, 1, 8, 4'b0000};
        tbl[7]  = '{6'b000010, 5, 0, 9, 4'b0100};
        tbl[8]  = '{6'b000010, 14, 0, 18, 4'b0100};
        tbl[9]  = '{6'b100010, 0, 14, 19, 4'b0101};
        tbl[10] = '{6'b010000, 0, 0, 5, 4'b0000};
        do_reset();
        chk("reset_fault", 32'(fault), 32'd0);
        foreach (tbl[i]) begin
            run_insn(tbl[i].cls, tbl[i].fw, tbl[i].mw, cyc, wb);
            chk($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(tbl[i].cyc));
            chk($sformatf("vec%0d_wb", i), 32'(wb), 32'(tbl[i].wb));
        end
        chk("retired_after_table", 32'(retired), 32'd11);
        // reset while a load waits in MEM
        {is_load, is_store, is_branch, is_jmp, rd_w, illegal, br_taken} = 7'b1000100;
        step(1'b1, REQ | INST | IRW, "rm_fetch");
        step(1'b0, '0, "rm_decode");
        step(1'b0, '0, "rm_exec");
        step(1'b0, REQ, "rm_mem0");
        step(1'b0, REQ, "rm_mem1");
        rst_n = 1'b0;
        #1;
        exp_ret = 0;
        chk("rst_in_mem_outs", 32'(outs), 32'(REQ | INST));
        chk("rst_in_mem_retired", 32'(retired), 32'd0);
        step(1'b0, REQ | INST, "rm_hold");
        rst_n = 1'b1;
        // illegal opcode halts, absorbing; reset pulse recovers
        run_insn(6'b000010, 0, 0, cyc, wb);
        {is_load, is_store, is_branch, is_jmp, rd_w, illegal, br_taken} = 7'b0000000;
        step(1'b1, REQ | INST | IRW, "ill_fetch");
        illegal = 1'b1;
        step(1'b0, '0, "ill_decode");
        for (int i = 0; i < 6; i++) begin
            {is_load, is_store, is_branch, is_jmp, rd_w, illegal, br_taken} = 7'($urandom);
            step(1'($urandom), HLT | FILL, "ill_halt");
        end
        bus.mem_ack = 1'b0;
        rst_n = 1'b0;
        #1;
        exp_ret = 0;
        chk("ill_reset_outs", 32'(outs), 32'(REQ | INST));
        chk("ill_reset_retired", 32'(retired), 32'd0);
        step(1'b0, REQ | INST, "ill_rst_hold");
        rst_n = 1'b1;
        // fetch timeout after 15 un-acked request cycles
        do_reset();
        for (int i = 0; i < 15; i++) step(1'b0, REQ | INST, "fto_fetch");
        for (int i = 0; i < 3; i++) step(1'($urandom), HLT | FTO, "fto_halt");
        // data-access timeout
        do_reset();
        {is_load, is_store, is_branch, is_jmp, rd_w, illegal, br_taken} = 7'b1000100;
        step(1'b1, REQ | INST | IRW, "mto_fetch");
        step(1'b0, '0, "mto_decode");
        step(1'b0, '0, "mto_exec");
        for (int i = 0; i < 15; i++) step(1'b0, REQ, "mto_mem");
        for (int i = 0; i < 3; i++) step(1'($urandom), HLT | FTO, "mto_halt");
        // retired counter wraps modulo 2^XLEN
        do_reset();
        for (int i = 0; i < (1 << XL) - 1; i++) run_insn(6'b000010, 0, 0, cyc, wb);
        chk("retired_max", 32'(retired), 32'((1 << XL) - 1));
        run_insn(6'b000010, 0, 0, cyc, wb);
        chk("retired_wrap", 32'(retired), 32'd0);
        // randomized instruction mix against the cycle-level model
        do_reset();
        for (int n = 0; n < 300; n++) begin
            int fw, mw, exp_cyc;
            logic brt;
            brt = 1'($urandom);
            case ($urandom_range(0, 4))
                0: cls = {4'b0000, 1'($urandom), brt};
                1: cls = {5'b10001, brt};
                2: cls = {5'b01000, brt};
                3: cls = {5'b00100, brt};
                default: cls = {5'b00011, brt};
            endcase
            fw = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 14) : $urandom_range(0, 2);
            mw = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 14) : $urandom_range(0, 2);
            exp_cyc = fw + 4 + ((cls[5] | cls[4]) ? mw + 1 : 0);
            run_insn(cls, fw, mw, cyc, wb);
            chk("rand_cycles", 32'(cyc), 32'(exp_cyc));
        end
        chk("rand_retired", 32'(retired), 32'(300 % (1 << XL)));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/core_seq.md
Name: core_seq

Overview:
- Multi-cycle sequencer for the RV32I core.
- Consumes the instruction decoder's classification outputs and a branch-compare result.
- Drives the enables for the datapath registers (IR, PC, MDR, register file).
- Owns the core's single shared memory port, sequencing instruction fetch and data access over a req/ack handshake.
- Detects illegal instructions and bus timeouts, halts on either, and counts retired instructions.

Parameters:
- XLEN, 32, width of the retired-instruction counter.
- TO_W, 8, width of the bus-timeout counter; a fault is raised after 2^TO_W-1 consecutive un-acked request cycles.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- is_load  in  1  decoded load; stable from DECODE through WB.
- is_store  in  1  decoded store.
- is_branch  in  1  decoded conditional branch.
- is_jmp  in  1  decoded JAL/JALR.
- rd_w  in  1  instruction writes rd.
- illegal  in  1  decoder found an unrecognised opcode.
- br_taken  in  1  ALU compare result; valid only in EXEC.
- mem_ack  in  1  memory accepts/completes the current request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write (store); valid while mem_req.
- mem_inst  out  1  1 = address is PC (fetch); 0 = address is ALU result.
- ir_we  out  1  capture mem rdata into IR.
- mdr_we  out  1  capture mem rdata into MDR.
- pc_we  out  1  update PC.
- pc_sel  out  1  0 = PC+4; 1 = branch/jump target.
- rf_we  out  1  register-file write enable.
- rf_src  out  2  00 = ALU, 01 = MDR, 10 = PC+4.
- halted  out  1  core stopped.
- fault  out  2  00 none, 01 illegal instruction, 10 bus timeout.
- retired  out  XLEN  retired-instruction count.

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH, retired=0, fault=00, halted=0, taken flag=0, timeout count=0.
  - Outputs during and after reset: mem_req=1, mem_inst=1, mem_we=0; all other enables 0; pc_sel=0; rf_src=00.
- Reset mid-transaction abandons it; memory must tolerate this.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. All outputs are 0 except as listed per state.
- FETCH:
  - mem_req=1, mem_inst=1, mem_we=0.
  - ir_we=mem_ack (Mealy).
  - On edge with mem_ack=1 -> DECODE.
- DECODE (1 cycle, register read):
  - illegal=1 -> HALT with fault=01.
  - Otherwise -> EXEC.
- EXEC (1 cycle):
  - taken flag <= is_jmp | (is_branch & br_taken).
  - is_load|is_store -> MEM; else -> WB.
- MEM:
  - mem_req=1, mem_inst=0, mem_we=is_store.
  - mdr_we=mem_ack & is_load.
  - On ack -> WB.
- WB (1 cycle):
  - pc_we=1, pc_sel=taken flag, rf_we=rd_w.
  - rf_src=10 if is_jmp, 01 if is_load, else 00.
  - retired <= retired+1, wrapping modulo 2^XLEN.
  - -> FETCH; taken flag cleared.
- HALT:
  - Absorbing until reset; halted=1, fault held.
  - All enables and mem_req 0; retired frozen.
- Handshake:
  - mem_req, mem_we and mem_inst stay stable until the edge where mem_ack=1 is sampled.
  - mem_req drops in the following cycle except for back-to-back FETCH, which cannot occur.
  - mem_ack outside FETCH/MEM is ignored.
- Timeout:
  - Counter increments each FETCH/MEM cycle with mem_ack=0 and clears on ack or state entry.
  - On reaching 2^TO_W-1 with mem_ack=0 -> HALT with fault=10.
  - If mem_ack=1 in the cycle the counter is at max, ack wins and there is no fault.
- Latency with zero-wait memory (ack in the first request cycle):
  - ALU/branch/jump: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load/store: 5 cycles.
  - Each wait cycle adds 1.
- Stores pass through WB with rf_we=0 (rd_w=0) so PC and retired update uniformly.
- br_taken outside EXEC has no effect; is_jmp overrides br_taken.
- illegal is sampled only in DECODE.

Test Plan:
- Reset, then ADD (rd_w=1, others 0), mem_ack always 1:
  - mem_req high cycle 0, ir_we cycle 0.
  - rf_we=1, rf_src=00, pc_we=1, pc_sel=0 in cycle 3.
  - retired=1 after cycle 3; next fetch in cycle 4.
- Load with mem_ack delayed 3 cycles in MEM:
  - mem_req=1, mem_inst=0, mem_we=0 held for 4 cycles.
  - mdr_we only on the ack cycle.
  - WB has rf_src=01, rf_we=1; 8 cycles total.
- Branch with br_taken=1 in EXEC, then 0 driven in WB -> WB pc_sel=1 (latched).
- Branch with br_taken=0 -> pc_sel=0, rf_we=0.
- JAL -> WB rf_src=10, pc_sel=1.
- illegal=1 in DECODE -> next cycle halted=1, fault=01, mem_req=0 forever.
- Pulse rst_n low -> FETCH, fault=00, retired=0.
- TO_W=4, mem_ack held 0 in FETCH -> halted=1, fault=10 after 15 request cycles.
- Repeat with ack in the 15th cycle -> no fault, DECODE follows.
- Preload retired=0xFFFFFFFF via 2^32-1 retirements (or a forced value) -> next WB gives retired=0.
- Assert rst_n low during MEM wait -> immediate FETCH, mem_inst=1, retired unchanged from before reset except cleared to 0.
